// File: rtl/prv664_dbg_pkg.sv
// Shared types and constants for the per-hart debug controller.
package prv664_dbg_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESUME,
      HALTW
   } dbgc_state_t;

   localparam logic [2:0] CMDERR_NONE       = 3'd0;
   localparam logic [2:0] CMDERR_BUSY       = 3'd1;
   localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
   localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

   localparam logic [15:0] REGNO_DCSR      = 16'h07B0;
   localparam logic [15:0] REGNO_DPC       = 16'h07B1;
   localparam logic [15:0] REGNO_DSCRATCH0 = 16'h07B2;
   localparam logic [15:0] REGNO_DSCRATCH1 = 16'h07B3;

   // Only the four debug CSRs are reachable; GPR/FPR regnos fall through as unsupported.
   function automatic logic regno_supported(input logic [15:0] regno);
      return (regno == REGNO_DCSR) || (regno == REGNO_DPC) ||
             (regno == REGNO_DSCRATCH0) || (regno == REGNO_DSCRATCH1);
   endfunction

endpackage

// File: rtl/dbg_tmo_cnt.sv
// Saturating cycles-in-state counter; clr marks the first cycle of a new state.
module dbg_tmo_cnt #(
   parameter int CNT_W = 11
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             clr,
   input  logic [CNT_W-1:0] cmp,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // The entry cycle counts as zero, so expired fires on the cmp-th cycle in the state.
   assign cnt_next = clr ? '0 : cnt_reg;
   assign expired  = ({1'b0, cnt_next} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, cmp};

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_reg <= '0;
      end else if (cnt_next != '1) begin
         cnt_reg <= cnt_next + CNT_W'(1);
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/hart_dbg_ctrl.sv
// Per-hart debug controller: halt sequencing, resume handshake and abstract
// register commands on the debug CSRs.
module hart_dbg_ctrl
   import prv664_dbg_pkg::*;
#(
   parameter int RESUME_TMO = 256,
   parameter int HALT_TMO   = 1024,
   parameter int CNT_W      = 11
) (
   input  logic            clk_i,
   input  logic            srst_i,
   input  logic            dm_haltreq,
   input  logic            dm_resumereq,
   input  logic            cmd_valid,
   input  logic            cmd_write,
   input  logic [15:0]     cmd_regno,
   input  logic [XLEN-1:0] cmd_wdata,
   input  logic            cmderr_clr,
   output logic            busy,
   output logic [2:0]      cmderr,
   output logic [XLEN-1:0] cmd_rdata,
   output logic            resumeack,
   output logic            tmo_err,
   input  logic            hart_halted,
   input  logic            hart_run,
   input  logic [XLEN-1:0] dpc,
   input  logic [XLEN-1:0] dcsr,
   input  logic [XLEN-1:0] dscratch0,
   input  logic [XLEN-1:0] dscratch1,
   output logic            debug_haltreq,
   output logic            resumereq,
   output logic            debug_csren,
   output logic [11:0]     debug_csrindex,
   output logic [XLEN-1:0] debug_csrdata
);

   dbgc_state_t     state_reg;
   dbgc_state_t     state_prev_reg;
   logic [2:0]      cmderr_reg;
   logic [XLEN-1:0] cmd_rdata_reg;
   logic            resumeack_reg;
   logic            tmo_err_reg;
   logic            debug_haltreq_reg;
   logic            resumereq_reg;
   logic            debug_csren_reg;
   logic [11:0]     debug_csrindex_reg;
   logic [XLEN-1:0] debug_csrdata_reg;
   logic            cmd_write_reg;
   logic [15:0]     cmd_regno_reg;

   logic             state_entry;
   logic [CNT_W-1:0] tmo_cmp;
   logic             tmo_expired;
   logic [XLEN-1:0]  csr_vals [4];

   // Supported regnos are 0x7B0..0x7B3, so the low two bits pick the CSR.
   assign csr_vals[0] = dcsr;
   assign csr_vals[1] = dpc;
   assign csr_vals[2] = dscratch0;
   assign csr_vals[3] = dscratch1;

   assign state_entry = (state_reg != state_prev_reg);
   assign tmo_cmp     = (state_reg == HALTW) ? CNT_W'(HALT_TMO) : CNT_W'(RESUME_TMO);

   dbg_tmo_cnt #(
      .CNT_W (CNT_W)
   ) u_tmo_cnt (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .clr     (state_entry),
      .cmp     (tmo_cmp),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_reg          <= IDLE;
         state_prev_reg     <= IDLE;
         cmderr_reg         <= CMDERR_NONE;
         cmd_rdata_reg      <= '0;
         resumeack_reg      <= 1'b0;
         tmo_err_reg        <= 1'b0;
         debug_haltreq_reg  <= 1'b0;
         resumereq_reg      <= 1'b0;
         debug_csren_reg    <= 1'b0;
         debug_csrindex_reg <= '0;
         debug_csrdata_reg  <= '0;
         cmd_write_reg      <= 1'b0;
         cmd_regno_reg      <= '0;
      end else begin
         state_prev_reg  <= state_reg;
         resumereq_reg   <= 1'b0;
         debug_csren_reg <= 1'b0;
         // Any error set below overrides this clear.
         if (cmderr_clr) cmderr_reg <= CMDERR_NONE;

         unique case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmderr_reg == CMDERR_NONE) begin
                     if (!hart_halted) begin
                        cmderr_reg <= CMDERR_HALTRESUME;
                     end else if (!regno_supported(cmd_regno)) begin
                        cmderr_reg <= CMDERR_NOTSUP;
                     end else begin
                        state_reg     <= EXEC;
                        cmd_write_reg <= cmd_write;
                        cmd_regno_reg <= cmd_regno;
                        if (cmd_write) begin
                           debug_csren_reg    <= 1'b1;
                           debug_csrindex_reg <= cmd_regno[11:0];
                           debug_csrdata_reg  <= cmd_wdata;
                        end
                     end
                  end
               end else if (dm_haltreq) begin
                  if (!hart_halted) begin
                     state_reg         <= HALTW;
                     debug_haltreq_reg <= 1'b1;
                  end
               end else if (dm_resumereq) begin
                  if (hart_halted) begin
                     state_reg     <= RESUME;
                     resumereq_reg <= 1'b1;
                     resumeack_reg <= 1'b0;
                  end else if (hart_run) begin
                     resumeack_reg <= 1'b1;
                  end
               end
            end
            EXEC: begin
               if (cmd_valid && cmderr_reg == CMDERR_NONE) cmderr_reg <= CMDERR_BUSY;
               if (!cmd_write_reg) cmd_rdata_reg <= csr_vals[cmd_regno_reg[1:0]];
               state_reg <= IDLE;
            end
            RESUME: begin
               if (cmd_valid && cmderr_reg == CMDERR_NONE) cmderr_reg <= CMDERR_BUSY;
               if (hart_run) begin
                  resumeack_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else if (tmo_expired) begin
                  tmo_err_reg <= 1'b1;
                  state_reg   <= IDLE;
               end
            end
            HALTW: begin
               if (cmd_valid && cmderr_reg == CMDERR_NONE) cmderr_reg <= CMDERR_HALTRESUME;
               if (hart_halted || !dm_haltreq) begin
                  debug_haltreq_reg <= 1'b0;
                  state_reg         <= IDLE;
               end else if (tmo_expired) begin
                  debug_haltreq_reg <= 1'b0;
                  tmo_err_reg       <= 1'b1;
                  state_reg         <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy           = (state_reg == EXEC) || (state_reg == RESUME);
   assign cmderr         = cmderr_reg;
   assign cmd_rdata      = cmd_rdata_reg;
   assign resumeack      = resumeack_reg;
   assign tmo_err        = tmo_err_reg;
   assign debug_haltreq  = debug_haltreq_reg;
   assign resumereq      = resumereq_reg;
   assign debug_csren    = debug_csren_reg;
   assign debug_csrindex = debug_csrindex_reg;
   assign debug_csrdata  = debug_csrdata_reg;

endmodule

// File: tb/tb_hart_dbg_ctrl.sv
// Directed bench for hart_dbg_ctrl with a timestamp-based activity model checked every cycle.
module tb_hart_dbg_ctrl;
   import prv664_dbg_pkg::*;

   localparam int RESUME_TMO = 256;
   localparam int HALT_TMO   = 1024;

   logic            clk_i = 1'b0;
   logic            srst_i = 1'b1;
   logic            dm_haltreq = 1'b0;
   logic            dm_resumereq = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_write = 1'b0;
   logic [15:0]     cmd_regno = '0;
   logic [XLEN-1:0] cmd_wdata = '0;
   logic            cmderr_clr = 1'b0;
   logic            busy;
   logic [2:0]      cmderr;
   logic [XLEN-1:0] cmd_rdata;
   logic            resumeack;
   logic            tmo_err;
   logic            hart_halted = 1'b0;
   logic            hart_run = 1'b1;
   logic [XLEN-1:0] dpc = 64'h0000_0000_8000_0044;
   logic [XLEN-1:0] dcsr = 64'h0000_0000_4000_B003;
   logic [XLEN-1:0] dscratch0 = 64'h1111_2222_3333_4444;
   logic [XLEN-1:0] dscratch1 = 64'h5555_6666_7777_8888;
   logic            debug_haltreq;
   logic            resumereq;
   logic            debug_csren;
   logic [11:0]     debug_csrindex;
   logic [XLEN-1:0] debug_csrdata;

   int n_checks = 0;
   int n_fail   = 0;

   hart_dbg_ctrl #(
      .RESUME_TMO (RESUME_TMO),
      .HALT_TMO   (HALT_TMO),
      .CNT_W      (11)
   ) dut (
      .clk_i          (clk_i),
      .srst_i         (srst_i),
      .dm_haltreq     (dm_haltreq),
      .dm_resumereq   (dm_resumereq),
      .cmd_valid      (cmd_valid),
      .cmd_write      (cmd_write),
      .cmd_regno      (cmd_regno),
      .cmd_wdata      (cmd_wdata),
      .cmderr_clr     (cmderr_clr),
      .busy           (busy),
      .cmderr         (cmderr),
      .cmd_rdata      (cmd_rdata),
      .resumeack      (resumeack),
      .tmo_err        (tmo_err),
      .hart_halted    (hart_halted),
      .hart_run       (hart_run),
      .dpc            (dpc),
      .dcsr           (dcsr),
      .dscratch0      (dscratch0),
      .dscratch1      (dscratch1),
      .debug_haltreq  (debug_haltreq),
      .resumereq      (resumereq),
      .debug_csren    (debug_csren),
      .debug_csrindex (debug_csrindex),
      .debug_csrdata  (debug_csrdata)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: activities with start timestamps ----------------
   longint          cyc = 0;
   longint          t_start = 0;
   bit              in_exec = 0, in_resume = 0, in_haltw = 0;
   bit              model_on = 0;
   logic            op_is_write;
   logic [15:0]     op_regno;
   logic [2:0]      e_cmderr;
   logic [XLEN-1:0] e_rdata, e_data;
   logic [11:0]     e_idx;
   logic            e_resumeack, e_tmo, e_resumereq, e_csren;
   logic [2:0]      raise;

   function automatic logic [XLEN-1:0] csr_of(input logic [15:0] r);
      case (r)
         16'h07B0: return dcsr;
         16'h07B1: return dpc;
         16'h07B2: return dscratch0;
         default:  return dscratch1;
      endcase
   endfunction

   always @(posedge clk_i) begin
      cyc++;
      model_on = 1;
      if (srst_i) begin
         in_exec = 0; in_resume = 0; in_haltw = 0;
         e_cmderr = 0; e_rdata = 0; e_data = 0; e_idx = 0;
         e_resumeack = 0; e_tmo = 0; e_resumereq = 0; e_csren = 0;
      end else begin
         raise = 0;
         e_resumereq = 0;
         e_csren = 0;
         if (in_exec) begin
            if (cmd_valid) raise = 3'd1;
            if (!op_is_write) e_rdata = csr_of(op_regno);
            in_exec = 0;
         end else if (in_resume) begin
            if (cmd_valid) raise = 3'd1;
            if (hart_run) begin
               e_resumeack = 1; in_resume = 0;
            end else if (cyc - t_start >= RESUME_TMO) begin
               e_tmo = 1; in_resume = 0;
            end
         end else if (in_haltw) begin
            if (cmd_valid) raise = 3'd4;
            if (hart_halted || !dm_haltreq) begin
               in_haltw = 0;
            end else if (cyc - t_start >= HALT_TMO) begin
               e_tmo = 1; in_haltw = 0;
            end
         end else if (cmd_valid) begin
            if (e_cmderr == 0) begin
               if (!hart_halted) raise = 3'd4;
               else if (!(cmd_regno inside {[16'h07B0:16'h07B3]})) raise = 3'd2;
               else begin
                  in_exec = 1; t_start = cyc;
                  op_is_write = cmd_write; op_regno = cmd_regno;
                  if (cmd_write) begin
                     e_csren = 1; e_idx = cmd_regno[11:0]; e_data = cmd_wdata;
                  end
               end
            end
         end else if (dm_haltreq) begin
            if (!hart_halted) begin in_haltw = 1; t_start = cyc; end
         end else if (dm_resumereq) begin
            if (hart_halted) begin
               in_resume = 1; t_start = cyc; e_resumereq = 1; e_resumeack = 0;
            end else if (hart_run) begin
               e_resumeack = 1;
            end
         end
         if (raise != 0 && e_cmderr == 0) e_cmderr = raise;
         else if (cmderr_clr) e_cmderr = 0;
      end
   end

   always @(negedge clk_i) begin
      if (model_on) begin
         chk("busy", busy, in_exec || in_resume);
         chk("cmderr", cmderr, e_cmderr);
         chk("cmd_rdata", cmd_rdata, e_rdata);
         chk("resumeack", resumeack, e_resumeack);
         chk("tmo_err", tmo_err, e_tmo);
         chk("debug_haltreq", debug_haltreq, in_haltw);
         chk("resumereq", resumereq, e_resumereq);
         chk("debug_csren", debug_csren, e_csren);
         chk("debug_csrindex", debug_csrindex, e_idx);
         chk("debug_csrdata", debug_csrdata, e_data);
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [15:0] r, input logic [63:0] d);
      cmd_valid = 1; cmd_write = wr; cmd_regno = r; cmd_wdata = d;
      tick(1);
      cmd_valid = 0;
   endtask

   task automatic clear_err();
      cmderr_clr = 1; tick(1); cmderr_clr = 0;
   endtask

   int hcount;
   int n;

   initial begin
      tick(2);
      srst_i = 0;
      chk("reset_busy", busy, 0);
      chk("reset_cmderr", cmderr, 0);
      chk("reset_haltreq", debug_haltreq, 0);
      tick(1);

      // halt: hart acknowledges five cycles after the request is accepted
      dm_haltreq = 1;
      tick(1);
      hcount = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin hart_halted = 1; hart_run = 0; end
         if (debug_haltreq) hcount++;
         tick(1);
      end
      dm_haltreq = 0;
      chk("halt_cycles", hcount, 5);
      chk("halt_no_tmo", tmo_err, 0);

      // write dpc
      issue(1, 16'h07B1, 64'h0000_0000_8000_1000);
      chk("wr_csren", debug_csren, 1);
      chk("wr_index", debug_csrindex, 12'h7B1);
      chk("wr_data", debug_csrdata, 64'h0000_0000_8000_1000);
      chk("wr_busy", busy, 1);
      tick(1);
      chk("wr_csren_off", debug_csren, 0);
      chk("wr_busy_off", busy, 0);
      chk("wr_index_hold", debug_csrindex, 12'h7B1);

      // read dcsr
      issue(0, 16'h07B0, 0);
      chk("rd_before", cmd_rdata, 0);
      tick(2);
      chk("rd_dcsr", cmd_rdata, 64'h0000_0000_4000_B003);

      // unsupported regno, then sticky-error ignore, then clear
      issue(0, 16'h1005, 0);
      chk("err_notsup", cmderr, 2);
      dcsr = 64'h0000_0000_0000_1234;
      issue(0, 16'h07B0, 0);
      tick(2);
      chk("err_ignored_rdata", cmd_rdata, 64'h0000_0000_4000_B003);
      chk("err_sticky", cmderr, 2);
      clear_err();
      chk("err_cleared", cmderr, 0);
      dcsr = 64'h0000_0000_4000_B003;

      // command during EXEC: busy error wins over a same-cycle clear
      issue(1, 16'h07B2, 64'hDEAD_BEEF_0000_0001);
      cmd_valid = 1; cmd_write = 1; cmd_regno = 16'h07B3; cmderr_clr = 1;
      tick(1);
      cmd_valid = 0; cmderr_clr = 0;
      chk("err_busy", cmderr, 1);
      chk("err_busy_no_csren", debug_csren, 0);
      clear_err();

      // command while running
      hart_halted = 0; hart_run = 1;
      issue(0, 16'h07B0, 0);
      chk("err_running", cmderr, 4);
      clear_err();

      // command beats halt; halt taken on the following cycle
      cmd_valid = 1; cmd_write = 0; cmd_regno = 16'h07B0; dm_haltreq = 1;
      tick(1);
      cmd_valid = 0;
      chk("cmd_beats_halt_err", cmderr, 4);
      chk("cmd_beats_halt_req", debug_haltreq, 0);
      tick(1);
      chk("halt_after_cmd", debug_haltreq, 1);
      issue(0, 16'h07B0, 0);
      dm_haltreq = 0;
      tick(1);
      chk("halt_drop", debug_haltreq, 0);
      chk("halt_drop_no_tmo", tmo_err, 0);
      clear_err();

      // resume: hart runs three cycles after the pulse
      hart_halted = 1; hart_run = 0;
      dm_resumereq = 1; tick(1); dm_resumereq = 0;
      chk("res_pulse", resumereq, 1);
      chk("res_busy", busy, 1);
      chk("res_ack_clr", resumeack, 0);
      tick(1);
      chk("res_pulse_end", resumereq, 0);
      tick(1);
      hart_halted = 0; hart_run = 1;
      tick(1);
      chk("res_ack", resumeack, 1);
      chk("res_busy_off", busy, 0);

      // resume timeout
      hart_halted = 1; hart_run = 0;
      dm_resumereq = 1; tick(1); dm_resumereq = 0;
      n = 0;
      while (!tmo_err && n < 400) begin tick(1); n++; end
      chk("res_tmo_cycles", n, 256);
      chk("res_tmo_no_ack", resumeack, 0);
      chk("res_tmo_busy", busy, 0);

      // reset in the middle of a resume
      dm_resumereq = 1; tick(1); dm_resumereq = 0;
      tick(2);
      srst_i = 1; tick(1); srst_i = 0;
      chk("rst_busy", busy, 0);
      chk("rst_ack", resumeack, 0);
      chk("rst_tmo", tmo_err, 0);
      chk("rst_pulse", resumereq, 0);

      // resume request while already running
      hart_halted = 0; hart_run = 1;
      dm_resumereq = 1; tick(1); dm_resumereq = 0;
      chk("run_ack", resumeack, 1);
      chk("run_busy", busy, 0);

      // halt beats resume while halted: nothing starts
      hart_halted = 1; hart_run = 0;
      dm_haltreq = 1; dm_resumereq = 1; tick(1); dm_resumereq = 0; dm_haltreq = 0;
      chk("halt_beats_res", resumereq, 0);
      chk("halt_beats_res_busy", busy, 0);

      // halt timeout
      hart_halted = 0; hart_run = 1;
      dm_haltreq = 1; tick(1);
      n = 0;
      while (!tmo_err && n < 1200) begin tick(1); n++; end
      chk("halt_tmo_cycles", n, 1024);
      dm_haltreq = 0;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
